// File: rtl/calc_cmd_sched.sv
// calc_cmd_sched: keypad-to-core command FIFO and READY/BUSY handshake scheduler.
// Optional CALC_CMD_SCHED_COLLAPSE_EN drops a repeated operator key matching the newest queued entry.
module calc_cmd_sched #(
  parameter int         DEPTH       = 4,
  parameter logic [3:0] PARK_CMD    = 4'b1101,
  parameter int         ACK_TIMEOUT = 64
) (
  input  logic                     clock,
  input  logic                     reset,
  input  logic                     key_valid,
  input  logic [3:0]               key_code,
  output logic                     key_ready,
  input  logic [1:0]               calc_status,
  output logic [3:0]               cmd,
  output logic                     calc_rst,
  output logic [$clog2(DEPTH):0]   fifo_count,
  output logic                     busy,
  output logic                     err,
  output logic                     timeout,
  output logic                     overflow,
  input  logic                     clr_err
);
  localparam int AW = $clog2(DEPTH);
  localparam int TW = $clog2(ACK_TIMEOUT) + 1;
  typedef enum logic [1:0] {IDLE, WAIT_ACK, WAIT_DONE, FAULT} state_t;
  state_t        state_q, state_d;
  logic [3:0]    mem_q [DEPTH];
  logic [AW-1:0] rd_q, rd_d, wr_q, wr_d;
  logic [AW:0]   cnt_q, cnt_d;
  logic [TW-1:0] timer_q, timer_d;
  logic [3:0]    cmd_q, cmd_d;
  logic          calc_rst_q, calc_rst_d, timeout_q, timeout_d, overflow_q, overflow_d;
  logic          key_ready_q, key_ready_d, err_q, err_d;
  logic          full, pop, flush, accept, dup, push;
  always_comb begin
    state_d    = state_q;
    cmd_d      = cmd_q;
    timer_d    = timer_q;
    calc_rst_d = 1'b0;
    timeout_d  = clr_err ? 1'b0 : timeout_q;
    overflow_d = clr_err ? 1'b0 : overflow_q;
    pop        = 1'b0;
    flush      = 1'b0;
    full       = cnt_q == (AW+1)'(DEPTH);
    case (state_q)
      IDLE: if (cnt_q != '0 && calc_status == 2'b10) begin
        pop     = 1'b1;
        cmd_d   = mem_q[rd_q];
        timer_d = '0;
        state_d = WAIT_ACK;
      end
      WAIT_ACK: begin
        if (calc_status == 2'b00) begin
          state_d = FAULT;
          flush   = 1'b1;
          cmd_d   = PARK_CMD;
        end else if (calc_status[0]) begin
          state_d = WAIT_DONE;
          timer_d = '0;
        end else if (timer_q == TW'(ACK_TIMEOUT - 1)) begin
          timeout_d = 1'b1;
          cmd_d     = PARK_CMD;
          state_d   = IDLE;
        end else timer_d = timer_q + 1'b1;
      end
      WAIT_DONE: begin
        if (calc_status == 2'b10) begin
          state_d = IDLE;
          cmd_d   = PARK_CMD;
        end else if (calc_status == 2'b00) begin
          state_d = FAULT;
          flush   = 1'b1;
          cmd_d   = PARK_CMD;
        end
      end
      default: begin
        flush = 1'b1;
        if (clr_err) begin
          calc_rst_d = 1'b1;
          timeout_d  = 1'b0;
          overflow_d = 1'b0;
          state_d    = IDLE;
        end
      end
    endcase
    // a key arriving on a full FIFO is still taken when the head leaves the same cycle
    accept = key_valid && state_q != FAULT && (!full || pop);
    if (key_valid && state_q != FAULT && full && !pop) overflow_d = 1'b1;
`ifdef CALC_CMD_SCHED_COLLAPSE_EN
    dup = cnt_q != '0 && key_code == mem_q[wr_q - AW'(1)] && key_code inside {[4'b1010:4'b1100]};
`else
    dup = 1'b0;
`endif
    push        = accept && !dup && !flush;
    cnt_d       = flush ? '0 : cnt_q + (AW+1)'(push) - (AW+1)'(pop);
    rd_d        = flush ? '0 : rd_q + AW'(pop);
    wr_d        = flush ? '0 : wr_q + AW'(push);
    key_ready_d = state_d != FAULT && cnt_d != (AW+1)'(DEPTH);
    err_d       = state_d == FAULT;
  end
  always_ff @(posedge clock) begin
    if (reset) begin
      state_q     <= IDLE;
      rd_q        <= '0;
      wr_q        <= '0;
      cnt_q       <= '0;
      timer_q     <= '0;
      cmd_q       <= PARK_CMD;
      calc_rst_q  <= 1'b0;
      timeout_q   <= 1'b0;
      overflow_q  <= 1'b0;
      key_ready_q <= 1'b1;
      err_q       <= 1'b0;
    end else begin
      state_q     <= state_d;
      rd_q        <= rd_d;
      wr_q        <= wr_d;
      cnt_q       <= cnt_d;
      timer_q     <= timer_d;
      cmd_q       <= cmd_d;
      calc_rst_q  <= calc_rst_d;
      timeout_q   <= timeout_d;
      overflow_q  <= overflow_d;
      key_ready_q <= key_ready_d;
      err_q       <= err_d;
    end
  end
  always_ff @(posedge clock) if (!reset && push) mem_q[wr_q] <= key_code;
  assign key_ready  = key_ready_q;
  assign cmd        = cmd_q;
  assign calc_rst   = calc_rst_q;
  assign fifo_count = cnt_q;
  assign busy       = state_q != IDLE || cnt_q != '0;
  assign err        = err_q;
  assign timeout    = timeout_q;
  assign overflow   = overflow_q;
endmodule

// File: doc/calc_cmd_sched.md
Name: calc_cmd_sched

Overview:
- Command scheduler between the debounced keypad and the calculator core.
- Queues key codes in a small FIFO and issues them to the core's 4-bit `cmd` input one at a time.
- Issues only when the core reports READY; tracks the READY→BUSY→READY handshake per command.
- Detects core error and acknowledge timeout, and generates a one-cycle core reset request on error clear.

Parameters:
- DEPTH, 4, FIFO entries; power of two, minimum 2.
- PARK_CMD, 4'b1101, code driven on `cmd` when no command is being issued.
- ACK_TIMEOUT, 64, cycles allowed in WAIT_ACK before abandoning the command; minimum 2.

Ports:
- clock  in  1  system clock, rising edge.
- reset  in  1  synchronous, active-high reset.
- key_valid  in  1  key code present this cycle.
- key_code  in  4  key code: 0-9 digits, 1010 add, 1011 sub, 1100 mul, 1110 equals, 1111 backspace.
- key_ready  out  1  FIFO can accept a key this cycle.
- calc_status  in  2  core status: 00 error, 01 busy, 10 ready, 11 treated as busy.
- cmd  out  4  command to the core.
- calc_rst  out  1  one-cycle reset request to the core.
- fifo_count  out  $clog2(DEPTH)+1  current occupancy.
- busy  out  1  high when state ≠ IDLE or FIFO non-empty.
- err  out  1  high while in FAULT.
- timeout  out  1  sticky acknowledge-timeout flag.
- overflow  out  1  sticky flag: key pushed while full.
- clr_err  in  1  single-cycle pulse: clear FAULT and sticky flags.

Behaviour:
- Reset (synchronous, active-high, overrides all other inputs, including mid-handshake):
  - state=IDLE, FIFO empty, cmd=PARK_CMD.
  - calc_rst=0, err=0, timeout=0, overflow=0.
  - key_ready=1, fifo_count=0, busy=0, timer=0.
- FIFO:
  - Push when key_valid && key_ready; key_ready = !full && state≠FAULT.
  - key_valid while full: key dropped, overflow←1.
  - Simultaneous push and pop on a full FIFO is accepted (count unchanged).
  - Read and write pointers wrap modulo DEPTH.
- IDLE:
  - If FIFO non-empty && calc_status==10: pop head into cmd, timer←0, go to WAIT_ACK.
  - Latency: key pushed into an empty FIFO in cycle N appears on cmd at edge N+2.
  - Otherwise cmd=PARK_CMD.
- WAIT_ACK (cmd holds the issued code):
  - calc_status==00 → FAULT.
  - calc_status∈{01,11} → WAIT_DONE, timer←0.
  - Otherwise timer++. When timer==ACK_TIMEOUT-1 and status is still 10: timeout←1, cmd←PARK_CMD, go to IDLE. The command is discarded, not retried.
- WAIT_DONE (cmd holds the issued code):
  - calc_status==10 → IDLE, cmd←PARK_CMD.
  - calc_status==00 → FAULT.
  - Otherwise stay; no timeout in this state (multiply may take many cycles).
- FAULT:
  - err=1, FIFO flushed on entry, cmd=PARK_CMD, keys rejected.
  - On clr_err: calc_rst=1 for exactly one cycle; err, timeout and overflow cleared; go to IDLE.
- clr_err outside FAULT clears timeout and overflow only; calc_rst stays 0.
- Same-cycle priority: reset > FAULT entry > clr_err > issue.
- busy is combinational from registered state and count; all other outputs are registered.

Optional Feature:
- Macro: CALC_CMD_SCHED_COLLAPSE_EN.
- Defined: a key equal to the FIFO's most recently written entry, where that entry is an operator (1010-1100), is not pushed. It still counts as accepted (key_ready unaffected), and overflow is not set.
- Not defined: every accepted key is queued; there is no comparison logic.

Test Plan:
- Reset, then push 5, 1010, 3, 1110 with calc_status held 10 and the bench model answering 01 for 3 cycles per command → cmd shows 5, 1010, 3, 1110 in order; fifo_count returns to 0; busy falls 1 cycle after the final READY.
- Fill the FIFO (DEPTH=4) with calc_status=01 → key_ready=0 after the 4th push; a 5th key_valid sets overflow=1; fifo_count=4.
- Issue 7 with calc_status held at 10 → timeout=1 at exactly ACK_TIMEOUT cycles after issue; cmd=PARK_CMD; the next queued key issues on the following ready.
- During WAIT_DONE drive calc_status=00 → err=1 next cycle, fifo_count=0; then pulse clr_err → calc_rst high one cycle, err=0, state IDLE.
- Assert reset in WAIT_ACK with 3 keys queued → next cycle cmd=PARK_CMD, fifo_count=0, all flags 0.
- With CALC_CMD_SCHED_COLLAPSE_EN: push 1010, 1010, 4 → only 1010 and 4 are queued (fifo_count=2); without the macro, 3 entries are queued.
